mem_arbiter: RTL

- Arbitrates the core's instruction bus (`ireq`/`iresp`) and data bus (`dreq`/`dresp`) onto one shared memory port.
- One outstanding transaction at a time, driven by a 3-state FSM: IDLE, ADDR, DATA.
- Sits between the `core` pipeline and the memory/cache interface. Both buses see the same valid / addr_ok / data_ok handshake they already use.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction and data buses, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise D beats I on every tie.
module mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_valid,
    input  logic [AW-1:0]   i_addr,
    output logic            i_addr_ok,
    output logic            i_data_ok,
    output logic [31:0]     i_data,

    input  logic            d_valid,
    input  logic [AW-1:0]   d_addr,
    input  logic [2:0]      d_size,
    input  logic [DW/8-1:0] d_strobe,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_addr_ok,
    output logic            d_data_ok,
    output logic [DW-1:0]   d_rdata,

    output logic            m_valid,
    output logic [AW-1:0]   m_addr,
    output logic [2:0]      m_size,
    output logic [DW/8-1:0] m_strobe,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_addr_ok,
    input  logic            m_data_ok,
    input  logic [DW-1:0]   m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // owner / last_grant encoding: 0 = instruction bus, 1 = data bus
    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic            m_valid_q, m_valid_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic [2:0]      req_size_q, req_size_d;
    logic [DW/8-1:0] req_strobe_q, req_strobe_d;
    logic [DW-1:0]   req_wdata_q, req_wdata_d;

    logic            grant_to_d;
    logic            addr_hs;
    logic            data_hs;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign grant_to_d = d_valid && (!i_valid || !last_grant_q);
`else
    assign grant_to_d = d_valid;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        req_addr_d   = req_addr_q;
        req_size_d   = req_size_q;
        req_strobe_d = req_strobe_q;
        req_wdata_d  = req_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_d      = ADDR;
                    owner_d      = grant_to_d;
                    last_grant_d = grant_to_d;
                    if (grant_to_d) begin
                        req_addr_d   = d_addr;
                        req_size_d   = d_size;
                        req_strobe_d = d_strobe;
                        req_wdata_d  = d_wdata;
                    end else begin
                        req_addr_d   = i_addr;
                        req_size_d   = 3'b010;
                        req_strobe_d = '0;
                        req_wdata_d  = '0;
                    end
                end
            end
            ADDR: begin
                if (m_addr_ok) begin
                    state_d = m_data_ok ? IDLE : DATA;
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        m_valid_d = (state_d == ADDR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            m_valid_q    <= 1'b0;
            req_addr_q   <= '0;
            req_size_q   <= '0;
            req_strobe_q <= '0;
            req_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            req_addr_q   <= req_addr_d;
            req_size_q   <= req_size_d;
            req_strobe_q <= req_strobe_d;
            req_wdata_q  <= req_wdata_d;
        end
    end

    // Handshakes are suppressed while reset is low so an abandoned transaction never completes.
    assign addr_hs = reset && (state_q == ADDR) && m_addr_ok;
    assign data_hs = reset && (((state_q == ADDR) && m_addr_ok && m_data_ok) ||
                               ((state_q == DATA) && m_data_ok));

    assign i_addr_ok = addr_hs && !owner_q;
    assign d_addr_ok = addr_hs &&  owner_q;
    assign i_data_ok = data_hs && !owner_q;
    assign d_data_ok = data_hs &&  owner_q;
    assign i_data    = i_data_ok ? m_rdata[31:0] : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;

    assign m_valid  = m_valid_q;
    assign m_addr   = req_addr_q;
    assign m_size   = req_size_q;
    assign m_strobe = req_strobe_q;
    assign m_wdata  = req_wdata_q;

endmodule
